// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard between ID and ID/EX. It tracks the outstanding writer of each
// register, stalls consumers until the result can be forwarded, and flags bypassed sources.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned LAT_W    = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned SCNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [REG_W-1:0]    issue_rs,
    input  logic                issue_rs_used,
    input  logic [REG_W-1:0]    issue_rt,
    input  logic                issue_rt_used,
    input  logic [REG_W-1:0]    issue_rd,
    input  logic                issue_rd_wr,
    input  logic [LAT_W-1:0]    issue_lat,
    input  logic                flush,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_rd,
    output logic                stall,
    output logic                issue_fire,
    output logic                fwd_rs,
    output logic                fwd_rt,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [SCNT_W-1:0]   stall_count
);

    logic [LAT_W-1:0]    r_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [SCNT_W-1:0]   r_stall_count;

    logic [LAT_W-1:0]    w_cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] w_pend_nxt;
    logic [SCNT_W-1:0]   w_stall_count_nxt;
    logic [NUM_REGS-1:0] w_set;

    logic                w_rs_zero;
    logic                w_rt_zero;
    logic                w_hz_rs;
    logic                w_hz_rt;
    logic                w_go;

    // Source lookup: a nonzero count is a hazard, a pending writer with zero count is a bypass.
    always_comb begin
        w_rs_zero  = ZERO_REG && (issue_rs == '0);
        w_rt_zero  = ZERO_REG && (issue_rt == '0);
        w_hz_rs    = issue_rs_used && !w_rs_zero && (r_cnt[issue_rs] != '0);
        w_hz_rt    = issue_rt_used && !w_rt_zero && (r_cnt[issue_rt] != '0);
        fwd_rs     = issue_rs_used && !w_rs_zero && r_pend[issue_rs] && (r_cnt[issue_rs] == '0);
        fwd_rt     = issue_rt_used && !w_rt_zero && r_pend[issue_rt] && (r_cnt[issue_rt] == '0);
        w_go       = issue_valid && !flush;
        stall      = w_go && (w_hz_rs || w_hz_rt);
        issue_fire = w_go && !stall;
    end

    // Destination decode for the issuing instruction; register 0 is never tracked when hardwired.
    always_comb begin
        w_set = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_set[r] = issue_fire && issue_rd_wr && (issue_rd == REG_W'(r));
        end
        if (ZERO_REG) begin
            w_set[0] = 1'b0;
        end
    end

    // Per-register update: a new writer beats both the countdown and an older writer's retirement.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            if (w_set[r]) begin
                w_cnt_nxt[r]  = issue_lat;
                w_pend_nxt[r] = 1'b1;
            end else if (r_cnt[r] != '0) begin
                w_cnt_nxt[r] = r_cnt[r] - LAT_W'(1);
            end else if (wb_valid && (wb_rd == REG_W'(r))) begin
                w_pend_nxt[r] = 1'b0;
            end
        end
    end

    // Saturating stall performance counter.
    always_comb begin
        w_stall_count_nxt = r_stall_count;
        if (stall && (r_stall_count != '1)) begin
            w_stall_count_nxt = r_stall_count + SCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_pend        <= '0;
            r_stall_count <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            r_pend        <= w_pend_nxt;
            r_stall_count <= w_stall_count_nxt;
        end
    end

    assign busy_vec    = r_pend;
    assign stall_count = r_stall_count;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-case load-use bubble logic in the CPU top.
- Tracks every architectural register's outstanding writer and the remaining cycles until that writer's result can be forwarded.
- Sits between ID and the ID/EX pipeline register. Drives the IF/ID stall and tells the EX forwarding muxes which sources come from the bypass network rather than the register file.
- Supports per-instruction producer latency, so multi-cycle units (loads, future mul/div) stall exactly as long as required.

Parameters:
NUM_REGS, 16, number of architectural registers
REG_W, 4, register index width (log2 NUM_REGS)
LAT_W, 2, width of producer latency field; max latency 2^LAT_W-1
ZERO_REG, 1, when 1 register 0 is hardwired zero: never tracked, never stalls
SCNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
issue_valid  in  1  ID holds an instruction requesting advance to EX
issue_rs  in  REG_W  first source register
issue_rs_used  in  1  first source read by the instruction
issue_rt  in  REG_W  second source register
issue_rt_used  in  1  second source read by the instruction
issue_rd  in  REG_W  destination register
issue_rd_wr  in  1  instruction writes issue_rd
issue_lat  in  LAT_W  cycles after issue before the result is forwardable (0 = ALU, 1 = load)
flush  in  1  squash the ID instruction this cycle (taken branch)
wb_valid  in  1  a register write retires in WB this cycle
wb_rd  in  REG_W  register written by WB
stall  out  1  hold PC and IF/ID; inject NOP into ID/EX
issue_fire  out  1  instruction advances this cycle
fwd_rs  out  1  rs value must come from the bypass network
fwd_rt  out  1  rt value must come from the bypass network
busy_vec  out  NUM_REGS  per-register pending-writer bit
stall_count  out  SCNT_W  saturating count of stall cycles

Behaviour:
- State per register r: cnt[r] (LAT_W bits) and pend[r] (1 bit).
- Reset (async, rst=1) clears all cnt, pend and stall_count to 0. With cnt all 0, stall=0, issue_fire=issue_valid&~flush, fwd_*=0, busy_vec=0.
- Combinational outputs:
  - hz_rs = issue_rs_used & cnt[issue_rs]!=0; hz_rt defined the same way for rt.
  - stall = issue_valid & ~flush & (hz_rs | hz_rt).
  - issue_fire = issue_valid & ~flush & ~stall.
  - fwd_rs = issue_rs_used & pend[issue_rs] & cnt[issue_rs]==0; fwd_rt defined the same way for rt.
  - If ZERO_REG=1, register 0 forces hz and fwd to 0.
- Per clock edge, each register r:
  - Priority 1: if issue_fire & issue_rd_wr & issue_rd==r (and not (ZERO_REG & r==0)), then cnt[r]<=issue_lat and pend[r]<=1.
  - Otherwise cnt[r] decrements when nonzero.
  - Otherwise pend[r] clears when wb_valid & wb_rd==r.
  - Issue set beats simultaneous WB clear and decrement on the same register (newer writer wins).
- Stall latency: a consumer issued the cycle after a latency-L producer stalls exactly L cycles. L=0 never stalls.
- flush takes priority over stall: flush=1 gives stall=0, issue_fire=0, no scoreboard update. Decrement and WB clear still proceed.
- stall_count increments on each cycle with stall=1 and saturates at all-ones (no wrap).
- Issue with issue_valid=0 changes nothing except decrement and WB clear.
- WB for a register with pend=0 is ignored.
- Reset asserted mid-stall clears stall in the same cycle (combinational from cleared state). No pending entry survives reset.

Test Plan:
- Reset, then issue rd=3 lat=1; next cycle issue rs=3 used -> stall=1 for 1 cycle, then issue_fire=1, fwd_rs=1; stall_count=1.
- Issue rd=5 lat=0, then rs=5, rt=5 used -> no stall, fwd_rs=fwd_rt=1. wb_valid wb_rd=5 -> busy_vec[5]=0 and later fwd_rs=0.
- Issue rd=2 lat=3, consumer rt=2 -> stall 3 consecutive cycles, stall_count=3. Same cycle flush=1 -> stall=0, issue_fire=0, count unchanged.
- ZERO_REG=1: issue rd=0 lat=3, then rs=0 -> no stall, busy_vec[0]=0.
- Same cycle: issue rd=7 lat=2 with wb_valid wb_rd=7 (older writer) -> pend[7]=1, cnt[7]=2.
- stall_count preloaded near max by forced stalls (SCNT_W=4 build): 20 stall cycles -> stall_count=15. Assert rst mid-stall -> stall=0, stall_count=0, busy_vec=0 immediately.
